// File: rtl/add_mp_stream_pkg.sv
// Shared types and default sizing for the multi-precision stream adder.
package add_mp_pkg;

  localparam int W_DEF         = 32;
  localparam int MAX_WORDS_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/add_mp_stream_slice.sv
// Combinational W-bit adder slice; one instance is chained word by word by add_mp_stream.
module add_slice_comb
  import add_mp_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/add_mp_stream.sv
// Multi-precision stream adder: LSW-first word streams, registered sum output.
// Optional subtract mode (A-B) is enabled by defining ADD_MP_STREAM_SUB_EN.
//
// state | meaning
// IDLE  | next accepted word is the LSW of a new operand (slice carry-in = cin)
// BUSY  | mid-operand (slice carry-in = carry from previous word)
module add_mp_stream
  import add_mp_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF,
  parameter int CW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cin,
`ifdef ADD_MP_STREAM_SUB_EN
  input  logic          in_sub,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_s,
  output logic [CW-1:0] out_idx,
  output logic          out_last,
  output logic          out_cout,
  output logic          out_err
);

  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_out_valid;
  logic [W-1:0]  r_out_s;
  logic [CW-1:0] r_out_idx;
  logic          r_out_last;
  logic          r_out_cout;
  logic          r_out_err;

  logic          w_accept;
  logic          w_term;
  logic          w_slice_cin;
  logic [W-1:0]  w_b;
  logic [W-1:0]  w_s;
  logic          w_cout;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  // Word count limit forces the operand to close even without in_last.
  assign w_term   = in_last || (r_cnt == LAST_IDX);

`ifdef ADD_MP_STREAM_SUB_EN
  logic r_sub;
  logic w_sub;

  // Subtract mode is latched from the LSW and held for the rest of the operand.
  assign w_sub       = (r_state == IDLE) ? in_sub : r_sub;
  assign w_b         = w_sub ? ~in_b : in_b;
  assign w_slice_cin = (r_state == IDLE) ? (in_sub ? 1'b1 : cin) : r_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (w_accept && (r_state == IDLE)) begin
      r_sub <= in_sub;
    end
  end
`else
  assign w_b         = in_b;
  assign w_slice_cin = (r_state == IDLE) ? cin : r_carry;
`endif

  add_slice_comb #(
    .W (W)
  ) u_slice (
    .a    (in_a),
    .b    (w_b),
    .cin  (w_slice_cin),
    .s    (w_s),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_carry <= w_cout;
      if (w_term) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= BUSY;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  // Single output register; a new accept replaces it in the same edge it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_s     <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_out_cout  <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_s     <= w_s;
      r_out_idx   <= r_cnt;
      r_out_last  <= w_term;
      r_out_cout  <= w_term && w_cout;
      r_out_err   <= w_term && !in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_s     = r_out_s;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign out_cout  = r_out_cout;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_add_mp_stream.sv
// Directed self-checking bench for add_mp_stream with hand-computed expectations.
module tb_add_mp_stream;

  localparam int W  = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cin;
  logic          in_sub;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_s;
  logic [CW-1:0] out_idx;
  logic          out_last;
  logic          out_cout;
  logic          out_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  add_mp_stream dut (
    .clk       (clk),
    .rst       (rst),
    .cin       (cin),
`ifdef ADD_MP_STREAM_SUB_EN
    .in_sub    (in_sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_err   (out_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word for one edge and check the registered result right after it.
  task automatic word(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic last, input logic [W-1:0] es, input int eidx,
                      input logic elast, input logic ecout, input logic eerr);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".s"},     64'(out_s),     64'(es));
    chk({tag, ".idx"},   64'(out_idx),   64'(eidx));
    chk({tag, ".last"},  64'(out_last),  64'(elast));
    chk({tag, ".cout"},  64'(out_cout),  64'(ecout));
    chk({tag, ".err"},   64'(out_err),   64'(eerr));
  endtask

  initial begin
    rst       = 1'b1;
    cin       = 1'b0;
    in_sub    = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_s",     64'(out_s),     64'd0);
    chk("rst.out_idx",   64'(out_idx),   64'd0);
    chk("rst.out_last",  64'(out_last),  64'd0);
    chk("rst.out_cout",  64'(out_cout),  64'd0);
    chk("rst.out_err",   64'(out_err),   64'd0);

    // Single word with wrap and carry out.
    word("single", 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 0, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    // Three-word carry chain, back to back.
    word("chain0", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    word("chain1", 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, 1, 1'b0, 1'b0, 1'b0);
    word("chain2", 32'd0,         32'd0, 1'b1, 32'd1, 2, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

    // Backpressure mid-operand: the stalled word must be taken exactly once.
    word("bp0", 32'd10, 32'd20, 1'b0, 32'd30, 0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_a      = 32'd1;
    in_b      = 32'd2;
    in_last   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp.in_ready",  64'(in_ready),  64'd0);
      chk("bp.out_valid", 64'(out_valid), 64'd1);
      chk("bp.out_s",     64'(out_s),     64'd30);
      chk("bp.out_idx",   64'(out_idx),   64'd0);
    end
    out_ready = 1'b1;
    word("bp1", 32'd1, 32'd2, 1'b0, 32'd3, 1, 1'b0, 1'b0, 1'b0);
    word("bp2", 32'd4, 32'd5, 1'b1, 32'd9, 2, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

    // Truncation at MAX_WORDS with a carry rippling through every word.
    cin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      word($sformatf("trunc%0d", i), 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0, i,
           (i == 7), (i == 7), (i == 7));
    end
    cin = 1'b0;
    word("trunc_next", 32'd5, 32'd6, 1'b1, 32'd11, 0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

    // Reset mid-operand leaves carry_q=1; restart must use cin=0 instead.
    word("rstmid0", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.out_valid", 64'(out_valid), 64'd0);
    word("rstmid1", 32'd2, 32'd3, 1'b1, 32'd5, 0, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();

`ifdef ADD_MP_STREAM_SUB_EN
    in_sub = 1'b1;
    word("sub", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 0, 1'b1, 1'b0, 1'b0);
    in_sub   = 1'b0;
    in_valid = 1'b0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
